atm_db_arbiter: RTL and testbench

//  Round-robin arbiter giving N ATM terminal FSMs exclusive, transaction-long

---
 rtl/atm_db_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_atm_db_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_db_arbiter.sv
// Purpose : round-robin arbiter granting one ATM terminal exclusive,
//           transaction-long access to the shared account database.
// Latency : grant rises on the first edge req is sampled high while idle;
//           release takes one edge, then one RELEASE turnaround cycle follows.
// Backpressure: requesters simply wait. The owner keeps the database until
//           it pulses done, drops req (abort), or is forced out by timeout.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   req_i        per-terminal request, held for the whole transaction
//   done_i       per-terminal 1-cycle "transaction finished" pulse
//   grant_o      registered one-hot grant (at most one bit set)
//   grant_id_o   index of the granted terminal, meaningful while busy_o=1
//   busy_o       database owned (HOLD state); always equals |grant_o
//   abort_o      1-cycle pulse: the owner dropped req without done
//   timeout_o    1-cycle pulse: forced release (tied low without the macro)
//   txn_count_o  count of completed (done) transactions, wraps
//
// Optional feature macro: ATM_ARB_TIMEOUT_EN enables the HOLD watchdog.

module atm_db_arbiter #(
    parameter int N_TERM  = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_TERM-1:0] req_i,
    input  logic [N_TERM-1:0] done_i,
    output logic [N_TERM-1:0] grant_o,
    output logic [ID_W-1:0]   grant_id_o,
    output logic              busy_o,
    output logic              abort_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  txn_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_TERM-1:0] grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              busy_q, busy_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;
    logic              rel_vld;

`ifdef ATM_ARB_TIMEOUT_EN
    localparam int HC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // Add an offset to a terminal index, wrapping at N_TERM rather than at
    // 2**ID_W so non-power-of-two terminal counts rotate correctly.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_TERM) begin
            s = s - N_TERM;
        end
        return s[ID_W-1:0];
    endfunction

    // Round-robin pick: scan from the highest offset down so the request
    // closest to rr_ptr (lowest offset) is the last writer and wins.
    logic            pick_vld;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] cand;

    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int i = N_TERM - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr_q, i);
            if (req_i[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        abort_d     = 1'b0;
        txn_count_d = txn_count_q;
        rel_vld     = 1'b0;
`ifdef ATM_ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d    = {{(N_TERM-1){1'b0}}, 1'b1} << pick_id;
                    grant_id_d = pick_id;
                    busy_d     = 1'b1;
                    state_d    = ST_HOLD;
`ifdef ATM_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end

            ST_HOLD: begin
                // done beats a simultaneous req drop, which beats the watchdog.
                // Other terminals' done/req changes are deliberately ignored.
                if (done_i[grant_id_q]) begin
                    rel_vld     = 1'b1;
                    txn_count_d = txn_count_q + CNT_W'(1);
                end else if (!req_i[grant_id_q]) begin
                    rel_vld = 1'b1;
                    abort_d = 1'b1;
                end
`ifdef ATM_ARB_TIMEOUT_EN
                else if (hold_cnt_q == HC_W'(TIMEOUT - 1)) begin
                    rel_vld   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
`endif

                if (rel_vld) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    // Released owner becomes lowest priority next round.
                    rr_ptr_d = wrap_add(grant_id_q, 1);
                    state_d  = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            abort_q     <= abort_d;
            txn_count_q <= txn_count_d;
        end
    end

`ifdef ATM_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // No watchdog: a stuck owner keeps the database indefinitely.
    assign timeout_o = 1'b0;
`endif

    assign grant_o     = grant_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = busy_q;
    assign abort_o     = abort_q;
    assign txn_count_o = txn_count_q;

endmodule

// File: tb/tb_atm_db_arbiter.sv
// Purpose : randomized + directed check of atm_db_arbiter against a
//           transaction-level reference model (owner / turnaround / pointer).
// Timing  : inputs change 1 time unit after each rising edge; outputs are
//           compared 1 time unit after each rising edge.
module tb_atm_db_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TMO = 16;
    localparam int CW  = 4;
`ifdef ATM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   done = '0;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           abort;
    logic           timeout;
    logic [CW-1:0]  txn_count;

    atm_db_arbiter #(
        .N_TERM (N),
        .ID_W   (IDW),
        .TIMEOUT(TMO),
        .CNT_W  (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .done_i     (done),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .busy_o     (busy),
        .abort_o    (abort),
        .timeout_o  (timeout),
        .txn_count_o(txn_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the database, whether the turnaround cycle
    // is pending, where the round-robin scan starts, and event pulses.
    int m_owner;
    int m_ptr;
    int m_count;
    int m_held;
    bit m_turn;
    bit m_abort;
    bit m_tmo;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_count = 0; m_held = 0;
        m_turn = 1'b0; m_abort = 1'b0; m_tmo = 1'b0;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1'b1;
    endtask

    task automatic model_step();
        bit found;
        found   = 1'b0;
        m_abort = 1'b0;
        m_tmo   = 1'b0;
        if (m_owner < 0) begin
            if (m_turn) begin
                m_turn = 1'b0;
            end else if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found   = 1'b1;
                        m_owner = (m_ptr + k) % N;
                    end
                end
                m_held = 0;
            end
        end else if (done[m_owner]) begin
            m_count = (m_count + 1) % (1 << CW);
            model_release();
        end else if (!req[m_owner]) begin
            m_abort = 1'b1;
            model_release();
        end else if (TMO_EN && m_held == TMO - 1) begin
            m_tmo = 1'b1;
            model_release();
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all();
        chk("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("abort", abort, m_abort);
        chk("timeout", timeout, m_tmo);
        chk("txn_count", txn_count, m_count);
        chk("onehot0", $onehot0(grant), 1);
        chk("busy_eq_or", busy, |grant);
        if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_count", txn_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int  exp_ord [5] = '{1, 2, 4, 8, 1};
    int  got_n;
    int  hc;
    int  at_cyc;
    bit  seen;
    logic prev_busy;
    int  r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single request, grant next edge, done completes it
        do_reset();
        req = 4'b0001;
        tick();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1);
        tick();
        done = 4'b0001;
        tick();
        done = '0;
        req  = '0;
        chk("t1_released", grant, 0);
        chk("t1_count", txn_count, 1);
        tick();
        tick();

        // 2: all request; each owner finishes after 3 HOLD cycles
        do_reset();
        req = '1;
        got_n = 0; hc = 0; prev_busy = 1'b0;
        for (int c = 0; c < 60 && got_n < 5; c++) begin
            done = '0;
            if (m_owner >= 0 && hc == 3) done[m_owner] = 1'b1;
            tick();
            if (busy && !prev_busy) begin
                chk("t2_order", grant, exp_ord[got_n]);
                got_n++;
                hc = 1;
            end else if (busy) begin
                hc++;
            end
            prev_busy = busy;
        end
        done = '0;
        chk("t2_grants_seen", got_n, 5);

        // 3: owner 2 aborts; terminal 3 is next
        do_reset();
        req = 4'b0100;
        tick();
        chk("t3_grant", grant, 4'b0100);
        tick();
        tick();
        req = 4'b1000;
        tick();
        chk("t3_abort", abort, 1);
        chk("t3_count", txn_count, 0);
        tick();
        chk("t3_abort_pulse", abort, 0);
        tick();
        chk("t3_next", grant, 4'b1000);
        done = 4'b1000;
        tick();
        done = '0;
        req  = '0;
        tick();

        // 4: foreign done ignored; async reset mid-HOLD
        do_reset();
        req = 4'b0010;
        tick();
        done = 4'b0010;
        tick();
        done = '0;
        tick();
        tick();
        chk("t4_regrant", grant, 4'b0010);
        done = 4'b1000;
        tick();
        done = '0;
        chk("t4_ignore", grant, 4'b0010);
        chk("t4_count", txn_count, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t4_async_grant", grant, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_count", txn_count, 0);
        do_reset();

        // 5: stuck owner
        req = 4'b0001;
`ifdef ATM_ARB_TIMEOUT_EN
        seen = 1'b0; at_cyc = 0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            tick();
            if (timeout) begin
                seen   = 1'b1;
                at_cyc = c;
            end
        end
        chk("t5_timeout_seen", seen, 1);
        chk("t5_timeout_cycle", at_cyc, 17);
        chk("t5_count", txn_count, 0);
        req = 4'b0011;
        tick();
        tick();
        chk("t5_ptr_advanced", grant, 4'b0010);
`else
        for (int c = 0; c < 110; c++) tick();
        chk("t5_stuck", grant, 4'b0001);
        chk("t5_no_timeout", timeout, 0);
`endif

        // 6: counter wrap with CNT_W=4
        do_reset();
        req = 4'b0001;
        for (int t = 0; t < 16; t++) begin
            tick();
            done = 4'b0001;
            tick();
            done = '0;
            tick();
            if (t == 14) chk("t6_count15", txn_count, 15);
        end
        chk("t6_wrap", txn_count, 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            done = '0;
            for (int k = 0; k < N; k++) begin
                if (k == m_owner) begin
                    r = $urandom_range(0, 15);
                    if (r < 4) begin
                        done[k] = 1'b1;
                        if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
                    end else if (r == 4) begin
                        req[k] = 1'b0;
                    end
                end else begin
                    if (!req[k]) req[k] = ($urandom_range(0, 2) == 0);
                    else if ($urandom_range(0, 19) == 0) req[k] = 1'b0;
                    if ($urandom_range(0, 31) == 0) done[k] = 1'b1;
                end
            end
            tick();
        end
        done = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
